router_fsm: RTL and testbench

- Packet-sequencing controller for the router's input datapath.
- Decodes the header address and sequences the register block's load, full, parity and error-check phases.
- Drives the write enable into the selected output FIFO and raises busy to hold off the source.
- Sits between the packet source, the input register block and the per-port output FIFOs.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_fsm.sv | 124 ++++++++++++
 tb/tb_router_fsm.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and default sizing for the router input-path controller.
package router_pkg;

    localparam int NUM_PORTS_DEF = 3;
    localparam int ADDR_W_DEF    = 2;

    // Packet-sequencing states. All eight 3-bit codes are assigned, so the
    // default recovery arm in the next-state logic only guards against
    // corruption of the state register.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller: decodes the header address, steps the
// register block through load/full/parity phases, strobes the selected
// output FIFO and holds off the source with busy.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    din,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic [ADDR_W-1:0]    port_sel,
    output logic                 write_enb_reg,
    output logic                 detect_addr,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy
);

    // Port count widened by one bit so the address compare never truncates.
    localparam logic [ADDR_W:0] NUM_PORTS_W = NUM_PORTS[ADDR_W:0];

    state_e state;
    state_e next_state;
    logic   din_valid;
    logic   din_empty;
    logic   sel_empty;
    logic   sel_soft_reset;

    assign din_valid = ({1'b0, din} < NUM_PORTS_W);

    // Per-port flag selection by header address and by latched port; an
    // out-of-range address selects nothing rather than indexing past the vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        din_empty      = 1'b0;
        sel_empty      = 1'b0;
        sel_soft_reset = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (din == ADDR_W'(i)) begin
                din_empty = fifo_empty[i];
            end
            if (port_sel == ADDR_W'(i)) begin
                sel_empty      = fifo_empty[i];
                sel_soft_reset = soft_reset[i];
            end
        end
    end

    // Next-state logic; a soft reset on the active port aborts the packet.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && din_valid) begin
                    next_state = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (sel_empty) next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        if (state != DECODE_ADDRESS && sel_soft_reset) begin
            next_state = DECODE_ADDRESS;
        end
    end

    // State register and destination latch with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state    <= DECODE_ADDRESS;
            port_sel <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid && din_valid) begin
                port_sel <= din;
            end
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        detect_addr   = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm. State is observed through the
// packed Moore output vector {detect, lfd, ld, laf, full, rst_int, wen, busy}.
module tb_router_fsm;

    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0010;
    localparam logic [7:0] O_LAF = 8'b0001_0011;
    localparam logic [7:0] O_FUL = 8'b0000_1001;
    localparam logic [7:0] O_CPE = 8'b0000_0101;
    localparam logic [7:0] O_LP  = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] din = 2'd0;
    logic       fifo_full = 1'b0;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_reset = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic [1:0] port_sel;
    logic       write_enb_reg, detect_addr, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    assign outs = {detect_addr, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_enb_reg, busy};

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .port_sel(port_sel), .write_enb_reg(write_enb_reg), .detect_addr(detect_addr),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (outs !== O_DA) begin
            errors++; $display("FAIL reset_outs: got %b want %b", outs, O_DA);
        end
        checks++;
        if (port_sel !== 2'd0) begin
            errors++; $display("FAIL reset_port_sel: got %0d want 0", port_sel);
        end
    endtask

    // Header to port 1, four LOAD_DATA cycles, then parity and back to decode.
    task automatic test_basic_packet();
        logic [7:0] exp_seq [8] = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
        fifo_empty = 3'b111;
        din = 2'd1;
        pkt_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) pkt_valid = 1'b0;
            step();
            if (i == 4) pkt_valid = 1'b0;
            checks++;
            if (outs !== exp_seq[i]) begin
                errors++; $display("FAIL basic_step%0d: got %b want %b", i, outs, exp_seq[i]);
            end
        end
        checks++;
        if (port_sel !== 2'd1) begin
            errors++; $display("FAIL basic_port_sel: got %0d want 1", port_sel);
        end
    endtask

    // Address 3 is not a valid port: stay in decode, keep the old port_sel.
    task automatic test_invalid_addr();
        din = 2'd3;
        pkt_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (outs !== O_DA || port_sel !== 2'd1) begin
                errors++; $display("FAIL invalid_addr%0d: got outs=%b sel=%0d want outs=%b sel=1",
                                   i, outs, port_sel, O_DA);
            end
        end
        pkt_valid = 1'b0;
    endtask

    // Port 2 busy: wait, then proceed when it drains; then full/after-full paths.
    task automatic test_wait_and_full();
        fifo_empty = 3'b011;
        din = 2'd2;
        pkt_valid = 1'b1;
        step();
        checks++;
        if (outs !== O_WTE || port_sel !== 2'd2) begin
            errors++; $display("FAIL wait_enter: got outs=%b sel=%0d want outs=%b sel=2", outs, port_sel, O_WTE);
        end
        step();
        checks++;
        if (outs !== O_WTE) begin
            errors++; $display("FAIL wait_hold: got %b want %b", outs, O_WTE);
        end
        fifo_empty = 3'b111;
        step();
        checks++;
        if (outs !== O_LFD) begin
            errors++; $display("FAIL wait_exit: got %b want %b", outs, O_LFD);
        end
        step();
        checks++;
        if (outs !== O_LD) begin
            errors++; $display("FAIL full_pre_ld: got %b want %b", outs, O_LD);
        end
        // fifo_full held four clocks: enter FULL, then remain.
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (outs !== O_FUL) begin
                errors++; $display("FAIL full_hold%0d: got %b want %b", i, outs, O_FUL);
            end
        end
        fifo_full = 1'b0;
        step();
        checks++;
        if (outs !== O_LAF) begin
            errors++; $display("FAIL laf_a: got %b want %b", outs, O_LAF);
        end
        step();
        checks++;
        if (outs !== O_LD) begin
            errors++; $display("FAIL laf_to_ld: got %b want %b", outs, O_LD);
        end
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        low_pkt_valid = 1'b1;
        step();
        checks++;
        if (outs !== O_LAF) begin
            errors++; $display("FAIL laf_b: got %b want %b", outs, O_LAF);
        end
        step();
        low_pkt_valid = 1'b0;
        checks++;
        if (outs !== O_LP) begin
            errors++; $display("FAIL laf_to_lp: got %b want %b", outs, O_LP);
        end
        // Full again during parity check: CPE must divert to FULL.
        fifo_full = 1'b1;
        step();
        checks++;
        if (outs !== O_CPE) begin
            errors++; $display("FAIL cpe: got %b want %b", outs, O_CPE);
        end
        step();
        checks++;
        if (outs !== O_FUL) begin
            errors++; $display("FAIL cpe_to_full: got %b want %b", outs, O_FUL);
        end
        fifo_full = 1'b0;
        parity_done = 1'b1;
        step();
        step();
        parity_done = 1'b0;
        pkt_valid = 1'b0;
        checks++;
        if (outs !== O_DA) begin
            errors++; $display("FAIL laf_parity_done: got %b want %b", outs, O_DA);
        end
    endtask

    // Soft reset only acts on the latched port.
    task automatic test_soft_reset();
        fifo_empty = 3'b110;
        din = 2'd0;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        checks++;
        if (outs !== O_WTE || port_sel !== 2'd0) begin
            errors++; $display("FAIL soft_wait: got outs=%b sel=%0d want outs=%b sel=0", outs, port_sel, O_WTE);
        end
        soft_reset = 3'b010;
        step();
        checks++;
        if (outs !== O_WTE) begin
            errors++; $display("FAIL soft_other_port: got %b want %b", outs, O_WTE);
        end
        soft_reset = 3'b001;
        step();
        soft_reset = 3'b000;
        checks++;
        if (outs !== O_DA || port_sel !== 2'd0) begin
            errors++; $display("FAIL soft_own_port: got outs=%b sel=%0d want outs=%b sel=0", outs, port_sel, O_DA);
        end
        fifo_empty = 3'b111;
    endtask

    // Synchronous reset mid-packet clears state and port_sel.
    task automatic test_reset_mid_packet();
        din = 2'd1;
        pkt_valid = 1'b1;
        step();
        step();
        checks++;
        if (outs !== O_LD || port_sel !== 2'd1) begin
            errors++; $display("FAIL midrst_pre: got outs=%b sel=%0d want outs=%b sel=1", outs, port_sel, O_LD);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pkt_valid = 1'b0;
        checks++;
        if (outs !== O_DA || port_sel !== 2'd0) begin
            errors++; $display("FAIL midrst_post: got outs=%b sel=%0d want outs=%b sel=0", outs, port_sel, O_DA);
        end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_invalid_addr();
        test_wait_and_full();
        test_soft_reset();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
